// File: rtl/coreaxitoahbl_pkg.sv
// Shared definitions for the AXI write-strobe analyser: burst FSM encoding,
// AHB HSIZE codes and a constant-foldable ceil-log2 helper.
package coreaxitoahbl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_ERR   = 2'd2
  } burst_state_e;

  localparam logic [2:0] HSIZE_BYTE   = 3'd0;
  localparam logic [2:0] HSIZE_HWORD  = 3'd1;
  localparam logic [2:0] HSIZE_WORD   = 3'd2;
  localparam logic [2:0] HSIZE_DWORD  = 3'd3;
  localparam logic [2:0] HSIZE_16BYTE = 3'd4;

  function automatic int clog2(input int value);
    int res;
    res = 32'sd0;
    for (int i = 32'sd0; i < 32'sd31; i++) begin
      res = ((32'sd1 << i) < value) ? (i + 32'sd1) : res;
    end
    return res;
  endfunction

endpackage

// File: rtl/coreaxitoahbl_strb_decode.sv
// Combinational strobe decoder: lane popcount, lowest active lane, run
// contiguity and AHB single-transfer legality for an STRB_W-lane strobe.
module coreaxitoahbl_strb_decode
  import coreaxitoahbl_pkg::*;
#(
  parameter int STRB_W = 8
) (
  input  logic [STRB_W-1:0]        strb_i,
  output logic [clog2(STRB_W):0]   pop_o,
  output logic [clog2(STRB_W)-1:0] first_o,
  output logic                     contig_o,
  output logic                     single_o
);

  localparam int CNT_W = clog2(STRB_W) + 1;
  localparam int FB_W  = clog2(STRB_W);

  logic [STRB_W:0]  ext_s;
  logic [CNT_W-1:0] rises_s;
  logic [CNT_W-1:0] align_s;

  // A run starts wherever a lane is set and the lane below it is clear
  always_comb begin
    ext_s   = {strb_i, 1'b0};
    pop_o   = {CNT_W{1'b0}};
    rises_s = {CNT_W{1'b0}};
    first_o = {FB_W{1'b0}};
    for (int i = STRB_W - 1; i >= 0; i--) begin
      pop_o   = pop_o + CNT_W'(strb_i[i]);
      rises_s = rises_s + CNT_W'(ext_s[i+1] & ~ext_s[i]);
      first_o = strb_i[i] ? FB_W'(i) : first_o;
    end
  end

  // Legal single transfer: one power-of-two run, naturally aligned
  always_comb begin
    contig_o = (rises_s <= CNT_W'(1));
    align_s  = {1'b0, first_o} & (pop_o - CNT_W'(1));
    single_o = contig_o
            && (pop_o != {CNT_W{1'b0}})
            && ((pop_o & (pop_o - CNT_W'(1))) == {CNT_W{1'b0}})
            && (align_s == {CNT_W{1'b0}});
  end

endmodule

// File: rtl/coreaxitoahbl_wstrb_beat_analyser.sv
// Per-beat / per-burst W-strobe analyser with one registered result stage.
// Optional macro COREAXITOAHBL_WSTRB_ZERO_DROP_EN suppresses empty non-last beats.
module coreaxitoahbl_wstrb_beat_analyser
  import coreaxitoahbl_pkg::*;
#(
  parameter int DATA_WIDTH    = 64,
  parameter int MAX_BURST_LEN = 16
) (
  input  logic                                          ACLK,
  input  logic                                          ARESET,
  input  logic                                          WVALID,
  output logic                                          WREADY,
  input  logic [DATA_WIDTH/8-1:0]                       WSTRBIn,
  input  logic                                          WLASTIn,
  output logic                                          beatValid,
  input  logic                                          beatReady,
  output logic [clog2(DATA_WIDTH/8):0]                  noValidBytes,
  output logic [clog2(DATA_WIDTH/8)-1:0]                firstByte,
  output logic                                          contiguous,
  output logic                                          singleXfer,
  output logic [2:0]                                    hsizeOut,
  output logic [clog2(MAX_BURST_LEN):0]                 beatIdx,
  output logic [clog2(MAX_BURST_LEN*(DATA_WIDTH/8)):0]  burstBytes,
  output logic                                          lastOut,
  output logic                                          lenErr
);

  localparam int STRB_W  = DATA_WIDTH / 8;
  localparam int CNT_W   = clog2(STRB_W) + 1;
  localparam int FB_W    = clog2(STRB_W);
  localparam int IDX_W   = clog2(MAX_BURST_LEN) + 1;
  localparam int BYTES_W = clog2(MAX_BURST_LEN * STRB_W) + 1;

  burst_state_e     state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d, idx_new_s;
  logic [BYTES_W-1:0] bytes_q, bytes_d, bytes_new_s;
  logic [BYTES_W:0]   sum_s;
  logic               err_q, err_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   pop_q, pop_d, pop_s;
  logic [FB_W-1:0]    first_q, first_d, first_s;
  logic               contig_q, contig_d, contig_s;
  logic               single_q, single_d, single_s;
  logic [2:0]         hsize_q, hsize_d, hsize_s;
  logic               last_q, last_d;
  logic               accept_s, fwd_s, drop_s, limit_s;

  coreaxitoahbl_strb_decode #(
    .STRB_W (STRB_W)
  ) u_decode (
    .strb_i   (WSTRBIn),
    .pop_o    (pop_s),
    .first_o  (first_s),
    .contig_o (contig_s),
    .single_o (single_s)
  );

`ifdef COREAXITOAHBL_WSTRB_ZERO_DROP_EN
  assign drop_s = (pop_s == {CNT_W{1'b0}}) && !WLASTIn;
`else
  assign drop_s = 1'b0;
`endif

  assign WREADY   = !ARESET && (!valid_q || beatReady);
  assign accept_s = WVALID && WREADY;
  assign fwd_s    = accept_s && !drop_s;

  // HSIZE code of a legal single transfer
  always_comb begin
    if (single_s) begin
      case (32'(pop_s))
        32'd1:   hsize_s = HSIZE_BYTE;
        32'd2:   hsize_s = HSIZE_HWORD;
        32'd4:   hsize_s = HSIZE_WORD;
        32'd8:   hsize_s = HSIZE_DWORD;
        32'd16:  hsize_s = HSIZE_16BYTE;
        default: hsize_s = HSIZE_BYTE;
      endcase
    end else begin
      hsize_s = HSIZE_BYTE;
    end
  end

  // State, result and accumulator registers
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q  <= ST_IDLE;
      idx_q    <= {IDX_W{1'b0}};
      bytes_q  <= {BYTES_W{1'b0}};
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
      pop_q    <= {CNT_W{1'b0}};
      first_q  <= {FB_W{1'b0}};
      contig_q <= 1'b0;
      single_q <= 1'b0;
      hsize_q  <= 3'd0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      bytes_q  <= bytes_d;
      err_q    <= err_d;
      valid_q  <= valid_d;
      pop_q    <= pop_d;
      first_q  <= first_d;
      contig_q <= contig_d;
      single_q <= single_d;
      hsize_q  <= hsize_d;
      last_q   <= last_d;
    end
  end

  // Burst FSM; the length limit only matters for a non-last beat
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_BURST: begin
        if (!accept_s) begin
          state_d = state_q;
        end else if (WLASTIn) begin
          state_d = ST_IDLE;
        end else if (limit_s) begin
          state_d = ST_ERR;
        end else begin
          state_d = ST_BURST;
        end
      end
      ST_ERR: begin
        if (accept_s && WLASTIn) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ERR;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Beat index / byte accumulation (both saturate once past the limit)
  always_comb begin
    sum_s = {1'b0, bytes_q} + (BYTES_W+1)'(pop_s);
    if (state_q == ST_IDLE) begin
      idx_new_s   = {IDX_W{1'b0}};
      bytes_new_s = BYTES_W'(pop_s);
    end else begin
      idx_new_s   = (idx_q >= IDX_W'(MAX_BURST_LEN)) ? idx_q : (idx_q + IDX_W'(1));
      bytes_new_s = sum_s[BYTES_W] ? {BYTES_W{1'b1}} : sum_s[BYTES_W-1:0];
    end
    limit_s = (idx_new_s == IDX_W'(MAX_BURST_LEN - 1));
    err_d   = err_q | (accept_s & limit_s & ~WLASTIn);
    if (accept_s) begin
      idx_d   = idx_new_s;
      bytes_d = bytes_new_s;
    end else begin
      idx_d   = idx_q;
      bytes_d = bytes_q;
    end
    if (fwd_s) begin
      valid_d  = 1'b1;
      pop_d    = pop_s;
      first_d  = first_s;
      contig_d = contig_s;
      single_d = single_s;
      hsize_d  = hsize_s;
      last_d   = WLASTIn;
    end else begin
      valid_d  = (accept_s || beatReady) ? 1'b0 : valid_q;
      pop_d    = pop_q;
      first_d  = first_q;
      contig_d = contig_q;
      single_d = single_q;
      hsize_d  = hsize_q;
      last_d   = last_q;
    end
  end

  assign beatValid    = valid_q;
  assign noValidBytes = pop_q;
  assign firstByte    = first_q;
  assign contiguous   = contig_q;
  assign singleXfer   = single_q;
  assign hsizeOut     = hsize_q;
  assign beatIdx      = idx_q;
  assign burstBytes   = bytes_q;
  assign lastOut      = last_q;
  assign lenErr       = err_q;

endmodule

// File: tb/tb_coreaxitoahbl_wstrb_beat_analyser.sv
// Bench for coreaxitoahbl_wstrb_beat_analyser (64-bit data, 4-beat limit):
// directed vector table, hand sequences and a random run against a burst model.
module tb_coreaxitoahbl_wstrb_beat_analyser;

  localparam int MAXB = 4;

`ifdef COREAXITOAHBL_WSTRB_ZERO_DROP_EN
  localparam bit ZDROP = 1'b1;
`else
  localparam bit ZDROP = 1'b0;
`endif

  logic       ACLK = 1'b0;
  logic       ARESET = 1'b1;
  logic       WVALID = 1'b0;
  logic       WREADY;
  logic [7:0] WSTRBIn = 8'h00;
  logic       WLASTIn = 1'b0;
  logic       beatValid;
  logic       beatReady = 1'b0;
  logic [3:0] noValidBytes;
  logic [2:0] firstByte;
  logic       contiguous;
  logic       singleXfer;
  logic [2:0] hsizeOut;
  logic [2:0] beatIdx;
  logic [5:0] burstBytes;
  logic       lastOut;
  logic       lenErr;

  always #5 ACLK = ~ACLK;

  coreaxitoahbl_wstrb_beat_analyser #(
    .DATA_WIDTH    (64),
    .MAX_BURST_LEN (MAXB)
  ) dut (
    .ACLK         (ACLK),
    .ARESET       (ARESET),
    .WVALID       (WVALID),
    .WREADY       (WREADY),
    .WSTRBIn      (WSTRBIn),
    .WLASTIn      (WLASTIn),
    .beatValid    (beatValid),
    .beatReady    (beatReady),
    .noValidBytes (noValidBytes),
    .firstByte    (firstByte),
    .contiguous   (contiguous),
    .singleXfer   (singleXfer),
    .hsizeOut     (hsizeOut),
    .beatIdx      (beatIdx),
    .burstBytes   (burstBytes),
    .lastOut      (lastOut),
    .lenErr       (lenErr)
  );

  typedef struct {
    int pop; int first; int contig; int single; int hsize; int idx; int bytes; int last;
  } res_t;

  typedef struct {
    logic [7:0] strb; bit last;
    int pop; int first; int contig; int single; int hsize; int idx; int bytes;
  } vec_t;

  int   tests = 0;
  int   fails = 0;
  res_t exp_r;
  bit   have_out = 1'b0;
  bit   err_m = 1'b0;
  int   n_beats = 0;
  int   byte_sum = 0;
  vec_t tbl [5];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference view of one strobe byte, straight from the lane rules
  function automatic res_t model_beat(input logic [7:0] s, input bit l);
    res_t r;
    int f;
    r.pop = $countones(s);
    f = 0;
    for (int i = 7; i >= 0; i--) if (s[i]) f = i;
    r.first  = f;
    r.contig = (s == 8'h00) || ((s >> f) == 8'((1 << r.pop) - 1));
    r.single = r.contig && (r.pop inside {1, 2, 4, 8}) && ((f % r.pop) == 0);
    r.hsize  = r.single ? $clog2(r.pop) : 0;
    r.last   = l;
    r.idx    = 0;
    r.bytes  = 0;
    return r;
  endfunction

  function automatic logic [7:0] rand_strb();
    int len;
    int pos;
    logic [7:0] s;
    case ($urandom_range(0, 3))
      0: s = 8'($urandom);
      1: s = 8'h00;
      2: begin
        len = $urandom_range(1, 8);
        pos = $urandom_range(0, 8 - len);
        s = 8'(((1 << len) - 1) << pos);
      end
      default: begin
        len = 1 << $urandom_range(0, 3);
        pos = len * $urandom_range(0, 8 / len - 1);
        s = 8'(((1 << len) - 1) << pos);
      end
    endcase
    return s;
  endfunction

  task automatic check_outputs();
    chk("beatValid", beatValid, have_out);
    chk("lenErr", lenErr, err_m);
    if (have_out) begin
      chk("noValidBytes", noValidBytes, exp_r.pop);
      chk("firstByte", firstByte, exp_r.first);
      chk("contiguous", contiguous, exp_r.contig);
      chk("singleXfer", singleXfer, exp_r.single);
      chk("hsizeOut", hsizeOut, exp_r.hsize);
      chk("beatIdx", beatIdx, exp_r.idx);
      chk("burstBytes", burstBytes, exp_r.bytes);
      chk("lastOut", lastOut, exp_r.last);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".WREADY"}, WREADY, 0);
    chk({tag, ".beatValid"}, beatValid, 0);
    chk({tag, ".noValidBytes"}, noValidBytes, 0);
    chk({tag, ".firstByte"}, firstByte, 0);
    chk({tag, ".contiguous"}, contiguous, 0);
    chk({tag, ".singleXfer"}, singleXfer, 0);
    chk({tag, ".hsizeOut"}, hsizeOut, 0);
    chk({tag, ".beatIdx"}, beatIdx, 0);
    chk({tag, ".burstBytes"}, burstBytes, 0);
    chk({tag, ".lastOut"}, lastOut, 0);
    chk({tag, ".lenErr"}, lenErr, 0);
  endtask

  // One clock: check current outputs, drive inputs, advance the model
  task automatic step(input bit v, input logic [7:0] s, input bit l, input bit rdy);
    res_t r;
    bit exp_rdy;
    check_outputs();
    WVALID = v;
    WSTRBIn = s;
    WLASTIn = l;
    beatReady = rdy;
    #1;
    exp_rdy = !ARESET && (!have_out || rdy);
    chk("WREADY", WREADY, exp_rdy);
    if (ARESET) begin
      have_out = 1'b0;
      err_m = 1'b0;
      n_beats = 0;
      byte_sum = 0;
    end else if (v && exp_rdy) begin
      r = model_beat(s, l);
      byte_sum += r.pop;
      r.bytes = (byte_sum > 63) ? 63 : byte_sum;
      r.idx = (n_beats > MAXB) ? MAXB : n_beats;
      if (n_beats == MAXB - 1 && !l) err_m = 1'b1;
      if (l) begin
        n_beats = 0;
        byte_sum = 0;
      end else begin
        n_beats++;
      end
      have_out = !(ZDROP && r.pop == 0 && !l);
      if (have_out) exp_r = r;
    end else if (rdy) begin
      have_out = 1'b0;
    end
    @(negedge ACLK);
  endtask

  initial begin
    tbl[0] = '{8'h0F, 1'b1, 4, 0, 1, 1, 2, 0, 4};
    tbl[1] = '{8'hF0, 1'b0, 4, 4, 1, 1, 2, 0, 4};
    tbl[2] = '{8'h3C, 1'b0, 4, 2, 1, 0, 0, 1, 8};
    tbl[3] = '{8'hFF, 1'b0, 8, 0, 1, 1, 3, 2, 16};
    tbl[4] = '{8'h81, 1'b1, 2, 0, 0, 0, 0, 3, 18};

    repeat (3) @(negedge ACLK);
    chk_all_zero("reset");
    ARESET = 1'b0;

    // Directed table, back-to-back with the consumer always ready
    for (int i = 0; i < 5; i++) begin
      step(1'b1, tbl[i].strb, tbl[i].last, 1'b1);
      chk($sformatf("tbl%0d.beatValid", i), beatValid, 1);
      chk($sformatf("tbl%0d.noValidBytes", i), noValidBytes, tbl[i].pop);
      chk($sformatf("tbl%0d.firstByte", i), firstByte, tbl[i].first);
      chk($sformatf("tbl%0d.contiguous", i), contiguous, tbl[i].contig);
      chk($sformatf("tbl%0d.singleXfer", i), singleXfer, tbl[i].single);
      chk($sformatf("tbl%0d.hsizeOut", i), hsizeOut, tbl[i].hsize);
      chk($sformatf("tbl%0d.beatIdx", i), beatIdx, tbl[i].idx);
      chk($sformatf("tbl%0d.burstBytes", i), burstBytes, tbl[i].bytes);
      chk($sformatf("tbl%0d.lastOut", i), lastOut, tbl[i].last);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Backpressure: three stalled cycles mid-burst
    step(1'b1, 8'h03, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'h0C, 1'b0, 1'b0);
      chk("stall.WREADY", WREADY, 0);
      chk("stall.noValidBytes", noValidBytes, 2);
      chk("stall.burstBytes", burstBytes, 2);
      chk("stall.beatIdx", beatIdx, 0);
    end
    step(1'b1, 8'h0C, 1'b0, 1'b1);
    chk("release.beatIdx", beatIdx, 1);
    chk("release.burstBytes", burstBytes, 4);
    step(1'b1, 8'h30, 1'b1, 1'b1);
    chk("release2.beatIdx", beatIdx, 2);
    chk("release2.burstBytes", burstBytes, 6);
    chk("release2.lastOut", lastOut, 1);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Over-length burst: 6 beats against a 4-beat limit
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 8'hFF, k == 5, 1'b1);
      chk($sformatf("len%0d.beatIdx", k), beatIdx, (k > MAXB) ? MAXB : k);
      chk($sformatf("len%0d.lenErr", k), lenErr, (k >= MAXB - 1) ? 1 : 0);
      chk($sformatf("len%0d.burstBytes", k), burstBytes, 8 * (k + 1));
    end
    step(1'b1, 8'h01, 1'b1, 1'b1);
    chk("after_err.beatIdx", beatIdx, 0);
    chk("after_err.burstBytes", burstBytes, 1);
    chk("after_err.lenErr", lenErr, 1);
    for (int k = 0; k < 10; k++) step(1'b1, 8'hFF, k == 9, 1'b1);
    chk("sat.burstBytes", burstBytes, 63);
    chk("sat.beatIdx", beatIdx, MAXB);

    // Reset while a result is held
    step(1'b1, 8'h03, 1'b0, 1'b1);
    step(1'b1, 8'h0C, 1'b0, 1'b0);
    ARESET = 1'b1;
    step(1'b1, 8'h30, 1'b0, 1'b0);
    chk_all_zero("midrst");
    ARESET = 1'b0;
    step(1'b1, 8'h01, 1'b1, 1'b1);
    chk("postrst.beatIdx", beatIdx, 0);
    chk("postrst.burstBytes", burstBytes, 1);
    chk("postrst.beatValid", beatValid, 1);

    // Empty-strobe beats
    step(1'b1, 8'h00, 1'b0, 1'b1);
    chk("zero0.beatValid", beatValid, ZDROP ? 0 : 1);
    step(1'b1, 8'h00, 1'b1, 1'b1);
    chk("zero1.beatValid", beatValid, 1);
    chk("zero1.beatIdx", beatIdx, 1);
    chk("zero1.burstBytes", burstBytes, 0);
    chk("zero1.noValidBytes", noValidBytes, 0);
    chk("zero1.contiguous", contiguous, 1);
    chk("zero1.singleXfer", singleXfer, 0);
    chk("zero1.lastOut", lastOut, 1);

    // Random traffic, back-pressure and occasional resets
    for (int c = 0; c < 2000; c++) begin
      ARESET = ($urandom_range(0, 149) == 0);
      step($urandom_range(0, 3) != 0, rand_strb(), $urandom_range(0, 5) == 0,
           $urandom_range(0, 3) != 0);
    end
    ARESET = 1'b0;
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check_outputs();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
